// File: rtl/sb_tx_arbiter.sv
// Sideband transmit arbiter: round-robin selection of NUM_REQ requesters feeding one serializer.
// Optional macro SB_ARB_FIXED_PRIO_EN gives requester 0 absolute priority over the rotating rest.
module sb_tx_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int MSG_W      = 64,
    parameter int GAP_CYCLES = 4,
    localparam int PTR_W     = $clog2(NUM_REQ)
) (
    input  logic                     clk_100MHz,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*MSG_W-1:0] req_msg_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     ser_valid_o,
    output logic [MSG_W-1:0]         ser_msg_o,
    input  logic                     ser_ready_i,
    input  logic                     ser_done_i,
    output logic [PTR_W-1:0]         grant_id_o,
    output logic                     busy_o,
    output logic [1:0]               fsm_state_o
);

    // Handshake: a requester transfers on a cycle where req_valid_i[i] && req_ready_o[i];
    // the serializer takes the message on a cycle where ser_valid_o && ser_ready_i.

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND      = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] GAP       = 2'd3;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

`ifdef SB_ARB_FIXED_PRIO_EN
    // Requester 0 is never part of the rotation, so the pointer lives in 1..NUM_REQ-1.
    localparam logic [PTR_W-1:0] RR_RST  = PTR_W'(1);
    localparam int               RR_WRAP = 1;
`else
    localparam logic [PTR_W-1:0] RR_RST  = '0;
    localparam int               RR_WRAP = 0;
`endif

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic [PTR_W-1:0] grant_q, grant_d;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] scan_idx;
    logic             accept;
    int               idx;
    int               nxt;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        idx       = 0;
`ifdef SB_ARB_FIXED_PRIO_EN
        if (req_valid_i[0]) begin
            win_found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_REQ) idx = idx - (NUM_REQ - 1);
                scan_idx = PTR_W'(idx);
                if (!win_found && req_valid_i[scan_idx]) begin
                    win_found = 1'b1;
                    win_idx   = scan_idx;
                end
            end
        end
`else
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            scan_idx = PTR_W'(idx);
            if (!win_found && req_valid_i[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
`endif
    end

    // Gated by reset so nothing can be offered while reset is held.
    assign accept = (state_q == IDLE) && win_found && !reset;

    always_comb begin
        req_ready_o = '0;
        if (accept) req_ready_o[win_idx] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gap_cnt_d = gap_cnt_q;
        msg_d     = msg_q;
        grant_d   = grant_q;
        nxt       = int'(win_idx) + 1;
        if (nxt >= NUM_REQ) nxt = RR_WRAP;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    msg_d   = req_msg_i[win_idx*MSG_W +: MSG_W];
                    grant_d = win_idx;
                    state_d = SEND;
`ifdef SB_ARB_FIXED_PRIO_EN
                    if (win_idx != '0) rr_ptr_d = PTR_W'(nxt);
`else
                    rr_ptr_d = PTR_W'(nxt);
`endif
                end
            end
            SEND: begin
                if (ser_ready_i) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (ser_done_i) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                // Leave on the last counted cycle so exactly GAP_CYCLES cycles are spent here.
                if (gap_cnt_q <= 4'd1) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= RR_RST;
            gap_cnt_q <= '0;
            msg_q     <= '0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gap_cnt_q <= gap_cnt_d;
            msg_q     <= msg_d;
            grant_q   <= grant_d;
        end
    end

    assign ser_valid_o = (state_q == SEND);
    assign ser_msg_o   = msg_q;
    assign grant_id_o  = grant_q;
    assign busy_o      = (state_q != IDLE);
    assign fsm_state_o = state_q;

endmodule

// File: doc/sb_tx_arbiter.md
SB_TX_ARBITER -- requirements
Module: sb_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of sideband message requesters (2..8).
REQ-002 Parameter MSG_W, default 64, sideband message width in bits.
REQ-003 Parameter GAP_CYCLES, default 4, mandatory idle cycles between consecutive messages (0..15).
REQ-004 clk_100MHz  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid_i  input  NUM_REQ  per-requester message pending.
REQ-007 req_msg_i  input  NUM_REQ*MSG_W  per-requester message; requester i occupies bits [i*MSG_W +: MSG_W].
REQ-008 req_ready_o  output  NUM_REQ  per-requester accept; transfer when req_valid_i[i] && req_ready_o[i].
REQ-009 ser_valid_o  output  1  message presented to sideband serializer.
REQ-010 ser_msg_o  output  MSG_W  latched message to serializer.
REQ-011 ser_ready_i  input  1  serializer accepts message when high with ser_valid_o.
REQ-012 ser_done_i  input  1  serializer finished shifting current message.
REQ-013 grant_id_o  output  $clog2(NUM_REQ)  index of requester owning the current message.
REQ-014 busy_o  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, SEND, WAIT_DONE, GAP.
REQ-016 IDLE: winner = first i with req_valid_i[i], searching from rr_ptr upward with wrap modulo NUM_REQ.
REQ-017 req_ready_o is combinational: only bit [winner] high, only in IDLE with some req_valid_i set; all bits low otherwise.
REQ-018 On transfer: latch req_msg_i[winner] into ser_msg_o, winner into grant_id_o, rr_ptr <= (winner+1) mod NUM_REQ, next state SEND.
REQ-019 SEND: ser_valid_o=1, ser_msg_o stable; on ser_ready_i=1 go WAIT_DONE next cycle.
REQ-020 WAIT_DONE: ser_valid_o=0; on ser_done_i=1 go GAP (or IDLE if GAP_CYCLES=0); ser_done_i ignored outside WAIT_DONE.
REQ-021 GAP: down-counter loaded with GAP_CYCLES on entry; exactly GAP_CYCLES cycles in GAP, then IDLE.
REQ-022 Accept-to-ser_valid_o latency: 1 cycle; minimum IDLE-to-IDLE message period: 3+GAP_CYCLES cycles.
REQ-023 Requester may drop req_valid_i before acceptance; arbiter re-evaluates every IDLE cycle, no lock on an unaccepted request.
REQ-024 All req_valid_i low in IDLE: stay IDLE, rr_ptr unchanged.
REQ-025 Requests arriving in SEND/WAIT_DONE/GAP are held off (ready low), not lost.
REQ-026 rr_ptr wraps from NUM_REQ-1 to 0.
REQ-027 Single active requester granted every message slot without starvation penalty.

Reset
REQ-028 reset=1 on a clock edge: state IDLE, rr_ptr 0, GAP counter 0, in-flight message discarded, regardless of current state.
REQ-029 Reset values: ser_valid_o 0, ser_msg_o 0, grant_id_o 0, busy_o 0, req_ready_o 0 while reset high.

Configuration
REQ-030 Macro SB_ARB_FIXED_PRIO_EN defined: requester 0 wins whenever req_valid_i[0]=1; otherwise round-robin among 1..NUM_REQ-1, rr_ptr never points to 0.
REQ-031 Macro undefined: pure round-robin over all NUM_REQ requesters per REQ-016.

Verification
REQ-032 Reset, then req_valid_i=3'b001, msg0=64'hA5A5_0000_0000_0001 -> req_ready_o=3'b001 same cycle, ser_valid_o=1 next cycle with ser_msg_o=msg0, grant_id_o=0.
REQ-033 req_valid_i=3'b111 held, ser_ready_i=1, ser_done_i pulsed 1 cycle after accept -> grants 0,1,2,0 (no macro); each grant spaced 3+4=7 cycles.
REQ-034 Same as REQ-033 with SB_ARB_FIXED_PRIO_EN -> grants 0,0,0,...; with only 3'b110 valid -> 1,2,1,2.
REQ-035 ser_ready_i held 0 for 10 cycles in SEND -> ser_valid_o and ser_msg_o stable 10 cycles, req_ready_o=0 throughout, no second accept.
REQ-036 reset asserted in WAIT_DONE -> next cycle state IDLE, busy_o=0, ser_valid_o=0, grant_id_o=0; next grant with 3'b111 goes to requester 0.
REQ-037 GAP_CYCLES=0, req_valid_i=3'b010 held -> WAIT_DONE returns directly to IDLE; message period exactly 3 cycles.
